// File: rtl/hwpe_ctrl_ctx_sched_pkg.sv
// Shared types for the HWPE job-context scheduler: slot states, engine FSM states
// and the bundle of single-bit engine status flags.
package hwpe_ctrl_ctx_sched_pkg;

    // Lifecycle of one register-file job context.
    typedef enum logic [1:0] {
        CtxFree  = 2'd0,
        CtxAcq   = 2'd1,
        CtxReady = 2'd2,
        CtxRun   = 2'd3
    } ctx_state_e;

    // Engine sequencing FSM.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StRun   = 2'd2,
        StDone  = 2'd3
    } sched_state_e;

    // Engine-facing status decoded from the FSM state.
    typedef struct packed {
        logic start;
        logic done;
        logic is_working;
    } ctx_sched_flags_t;

    // The engine counts as working from the start pulse until completion is seen.
    function automatic logic sched_is_busy(sched_state_e st);
        return (st == StStart) || (st == StRun);
    endfunction

endpackage

// File: rtl/hwpe_ctrl_ctx_sched.sv
// Job-context scheduler: hands out contexts through the acquire (test-and-set) path,
// commits them on trigger, runs the engine over them in ring order and routes the
// completion event back to the core that acquired the context.
module hwpe_ctrl_ctx_sched
    import hwpe_ctrl_ctx_sched_pkg::*;
#(
    parameter int unsigned N_CONTEXT = 2,
    parameter int unsigned N_CORES   = 16,
    parameter int unsigned N_EVT     = 2,
    parameter int unsigned CTXW      = $clog2(N_CONTEXT),
    parameter int unsigned CW        = $clog2(N_CORES),
    parameter int unsigned NFW       = $clog2(N_CONTEXT + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    input  logic                       acquire_req_i,
    input  logic [CW-1:0]              acquire_core_i,
    output logic                       acquire_ok_o,
    output logic [CTXW-1:0]            acquire_ctx_o,
    input  logic                       trigger_i,
    output logic                       start_o,
    input  logic                       engine_done_i,
    output logic                       done_o,
    output logic [N_CORES*N_EVT-1:0]   evt_o,
    output logic [CTXW-1:0]            pointer_ctx_o,
    output logic [CTXW-1:0]            running_ctx_o,
    output logic                       is_working_o,
    output logic [NFW-1:0]             nb_free_o
);

    localparam int unsigned EvtW = N_CORES * N_EVT;

    ctx_state_e       slot_st [N_CONTEXT];
    logic [CW-1:0]    owner   [N_CONTEXT];

    logic [CTXW-1:0]  pointer_q, pointer_d;
    logic [CTXW-1:0]  running_q, running_d;
    logic [CTXW-1:0]  last_acq_q, last_acq_d;

    sched_state_e     state_q, state_d;
    ctx_sched_flags_t flags;
    logic [EvtW-1:0]  evt;
    int unsigned      evt_idx;

    logic acq_fire, trig_fire, start_fire, done_fire;

    // Grant decision looks only at registered slot state, so a slot being freed
    // in the DONE cycle is not visible to an acquire in that same cycle.
    assign acquire_ok_o  = (slot_st[pointer_q] == CtxFree);
    assign acquire_ctx_o = pointer_q;
    assign acq_fire      = acquire_req_i && acquire_ok_o;
    // Trigger uses the pre-update last_acq, even if an acquire fires alongside it.
    assign trig_fire     = trigger_i && (slot_st[last_acq_q] == CtxAcq);
    assign start_fire    = (state_q == StStart);
    assign done_fire     = (state_q == StDone);

    // Per-slot state and owner; at most one event can target a given slot per
    // cycle because each event requires a different current state.
    for (genvar i = 0; i < N_CONTEXT; i++) begin : g_slot
        ctx_state_e    st_q, st_d;
        logic [CW-1:0] own_q, own_d;
        logic          sel_ptr, sel_last, sel_run;

        assign sel_ptr  = (pointer_q  == CTXW'(i));
        assign sel_last = (last_acq_q == CTXW'(i));
        assign sel_run  = (running_q  == CTXW'(i));

        // Next slot state from acquire / trigger / engine start / engine done.
        always_comb begin
            st_d  = st_q;
            own_d = own_q;
            if (clear_i) begin
                st_d  = CtxFree;
                own_d = '0;
            end else if (acq_fire && sel_ptr) begin
                st_d  = CtxAcq;
                own_d = acquire_core_i;
            end else if (trig_fire && sel_last) begin
                st_d  = CtxReady;
            end else if (start_fire && sel_run) begin
                st_d  = CtxRun;
            end else if (done_fire && sel_run) begin
                st_d  = CtxFree;
            end
        end

        // Slot state and owner registers.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                st_q  <= CtxFree;
                own_q <= '0;
            end else begin
                st_q  <= st_d;
                own_q <= own_d;
            end
        end

        assign slot_st[i] = st_q;
        assign owner[i]   = own_q;
    end

    // Ring pointers: acquire pointer, last granted slot and engine slot.
    always_comb begin
        pointer_d  = pointer_q;
        last_acq_d = last_acq_q;
        running_d  = running_q;
        if (clear_i) begin
            pointer_d  = '0;
            last_acq_d = '0;
            running_d  = '0;
        end else begin
            if (acq_fire) begin
                pointer_d  = pointer_q + CTXW'(1);
                last_acq_d = pointer_q;
            end
            if (done_fire) begin
                running_d = running_q + CTXW'(1);
            end
        end
    end

    // Pointer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pointer_q  <= '0;
            last_acq_q <= '0;
            running_q  <= '0;
        end else begin
            pointer_q  <= pointer_d;
            last_acq_q <= last_acq_d;
            running_q  <= running_d;
        end
    end

    // Engine FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Engine FSM next state; clear aborts any job without a completion pulse.
    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (slot_st[running_q] == CtxReady) state_d = StStart;
                StStart: state_d = StRun;
                StRun:   if (engine_done_i) state_d = StDone;
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // Engine FSM outputs and the owner-routed completion event.
    always_comb begin
        flags            = '0;
        flags.start      = (state_q == StStart);
        flags.done       = (state_q == StDone);
        flags.is_working = sched_is_busy(state_q);
        evt_idx          = 32'(owner[running_q]) * N_EVT;
        evt              = '0;
        if (flags.done) begin
            evt = EvtW'(1) << evt_idx;
        end
    end

    // Free-slot count from registered slot states.
    always_comb begin
        nb_free_o = '0;
        for (int i = 0; i < N_CONTEXT; i++) begin
            if (slot_st[i] == CtxFree) nb_free_o = nb_free_o + NFW'(1);
        end
    end

    assign start_o       = flags.start;
    assign done_o        = flags.done;
    assign is_working_o  = flags.is_working;
    assign evt_o         = evt;
    assign pointer_ctx_o = pointer_q;
    assign running_ctx_o = running_q;

endmodule

// File: tb/tb_hwpe_ctrl_ctx_sched.sv
// Scoreboard bench for the job-context scheduler: stimulus pushes the expected
// start/done pulses (cycle, context, event vector) and a negedge monitor pops them.
module tb_hwpe_ctrl_ctx_sched;

    localparam int unsigned NCtx   = 2;
    localparam int unsigned NCores = 16;
    localparam int unsigned NEvt   = 2;
    localparam int unsigned CtxW   = 1;
    localparam int unsigned Cw     = 4;
    localparam int unsigned NfW    = 2;
    localparam int unsigned EvtW   = NCores * NEvt;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              clear_i = 1'b0;
    logic              acquire_req_i = 1'b0;
    logic [Cw-1:0]     acquire_core_i = '0;
    logic              trigger_i = 1'b0;
    logic              engine_done_i = 1'b0;
    logic              acquire_ok_o;
    logic [CtxW-1:0]   acquire_ctx_o;
    logic              start_o;
    logic              done_o;
    logic [EvtW-1:0]   evt_o;
    logic [CtxW-1:0]   pointer_ctx_o;
    logic [CtxW-1:0]   running_ctx_o;
    logic              is_working_o;
    logic [NfW-1:0]    nb_free_o;

    hwpe_ctrl_ctx_sched #(
        .N_CONTEXT (NCtx),
        .N_CORES   (NCores),
        .N_EVT     (NEvt)
    ) u_dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .clear_i        (clear_i),
        .acquire_req_i  (acquire_req_i),
        .acquire_core_i (acquire_core_i),
        .acquire_ok_o   (acquire_ok_o),
        .acquire_ctx_o  (acquire_ctx_o),
        .trigger_i      (trigger_i),
        .start_o        (start_o),
        .engine_done_i  (engine_done_i),
        .done_o         (done_o),
        .evt_o          (evt_o),
        .pointer_ctx_o  (pointer_ctx_o),
        .running_ctx_o  (running_ctx_o),
        .is_working_o   (is_working_o),
        .nb_free_o      (nb_free_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit          is_done;
        int          cyc;
        int          ctx;
        logic [31:0] evt;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input bit is_done, input int at_cyc, input int ctx, input int evt_bit);
        exp_t e;
        e.is_done = is_done;
        e.cyc     = at_cyc;
        e.ctx     = ctx;
        e.evt     = (evt_bit < 0) ? 32'd0 : (32'd1 << evt_bit);
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic check_clean(input string tag);
        check({tag, "_acq_ok"},  32'(acquire_ok_o),  32'd1);
        check({tag, "_acq_ctx"}, 32'(acquire_ctx_o), 32'd0);
        check({tag, "_pointer"}, 32'(pointer_ctx_o), 32'd0);
        check({tag, "_running"}, 32'(running_ctx_o), 32'd0);
        check({tag, "_working"}, 32'(is_working_o),  32'd0);
        check({tag, "_nb_free"}, 32'(nb_free_o),     32'd2);
        check({tag, "_start"},   32'(start_o),       32'd0);
        check({tag, "_done"},    32'(done_o),        32'd0);
        check({tag, "_evt"},     evt_o,              32'd0);
    endtask

    // Monitor: every start/done pulse must match the head of the scoreboard.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (start_o || done_o) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: start=%0b done=%0b at cycle %0d, none expected",
                             start_o, done_o, cyc);
                end else begin
                    mon_e = sb_q.pop_front();
                    check(mon_e.is_done ? "done_kind" : "start_kind", 32'(done_o),
                          32'(mon_e.is_done));
                    check("pulse_cycle", 32'(cyc), 32'(mon_e.cyc));
                    check("pulse_running_ctx", 32'(running_ctx_o), 32'(mon_e.ctx));
                    check("pulse_evt", evt_o, mon_e.evt);
                end
            end else if (evt_o != '0) begin
                n_tests++;
                n_fail++;
                $display("FAIL stray_evt: got 0x%0h, expected 0x0 at cycle %0d", evt_o, cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;

        // Reset state.
        repeat (2) @(posedge clk_i);
        #1;
        check_clean("reset");
        rst_ni = 1'b1;
        tick();
        check_clean("post_reset");

        // Single job from core 3.
        acquire_req_i = 1'b1; acquire_core_i = 4'd3;
        #1;
        check("a_acq_ok", 32'(acquire_ok_o), 32'd1);
        check("a_acq_ctx", 32'(acquire_ctx_o), 32'd0);
        tick();
        acquire_req_i = 1'b0;
        #1;
        check("a_pointer", 32'(pointer_ctx_o), 32'd1);
        check("a_nb_free", 32'(nb_free_o), 32'd1);
        t = cyc;
        trigger_i = 1'b1;
        push_exp(1'b0, t + 2, 0, -1);
        tick();
        trigger_i = 1'b0;
        wait_until(t + 2);
        check("a_working", 32'(is_working_o), 32'd1);
        wait_until(t + 10);
        engine_done_i = 1'b1;
        push_exp(1'b1, t + 11, 0, 3 * NEvt);
        tick();
        engine_done_i = 1'b0;
        tick();
        check("a_nb_free_after", 32'(nb_free_o), 32'd2);
        check("a_idle_after", 32'(is_working_o), 32'd0);
        check("a_running_after", 32'(running_ctx_o), 32'd1);

        // Two jobs back-to-back (cores 1 and 2), full ring, DONE-cycle acquire.
        t = cyc;
        acquire_req_i = 1'b1; acquire_core_i = 4'd1;
        #1;
        check("b_acq1_ok", 32'(acquire_ok_o), 32'd1);
        check("b_acq1_ctx", 32'(acquire_ctx_o), 32'd1);
        tick();
        acquire_core_i = 4'd2; trigger_i = 1'b1;
        #1;
        check("b_acq2_ok", 32'(acquire_ok_o), 32'd1);
        check("b_acq2_ctx", 32'(acquire_ctx_o), 32'd0);
        tick();
        acquire_core_i = 4'd5;
        #1;
        check("b_acq3_full", 32'(acquire_ok_o), 32'd0);
        push_exp(1'b0, t + 3, 1, -1);
        tick();
        trigger_i = 1'b0; acquire_req_i = 1'b0;
        #1;
        check("b_pointer_kept", 32'(pointer_ctx_o), 32'd1);
        check("b_nb_free_zero", 32'(nb_free_o), 32'd0);
        wait_until(t + 6);
        engine_done_i = 1'b1;
        push_exp(1'b1, t + 7, 1, 1 * NEvt);
        push_exp(1'b0, t + 9, 0, -1);
        tick();
        engine_done_i = 1'b0;
        acquire_req_i = 1'b1; acquire_core_i = 4'd9;
        #1;
        check("b_acq_in_done", 32'(acquire_ok_o), 32'd0);
        tick();
        acquire_req_i = 1'b0;
        #1;
        check("b_nb_free_one", 32'(nb_free_o), 32'd1);
        check("b_pointer_one", 32'(pointer_ctx_o), 32'd1);
        wait_until(t + 12);
        engine_done_i = 1'b1;
        push_exp(1'b1, t + 13, 0, 2 * NEvt);
        tick();
        engine_done_i = 1'b0;
        tick();
        check("b_nb_free_two", 32'(nb_free_o), 32'd2);
        check("b_running_one", 32'(running_ctx_o), 32'd1);

        // Trigger with nothing acquired and done while idle are ignored.
        trigger_i = 1'b1; engine_done_i = 1'b1;
        tick();
        trigger_i = 1'b0; engine_done_i = 1'b0;
        tick();
        tick();
        check("c_nb_free", 32'(nb_free_o), 32'd2);
        check("c_idle", 32'(is_working_o), 32'd0);
        check("c_pointer", 32'(pointer_ctx_o), 32'd1);
        check("c_running", 32'(running_ctx_o), 32'd1);

        // Pointer wrap, then clear during RUN.
        t = cyc;
        acquire_req_i = 1'b1; acquire_core_i = 4'd6; trigger_i = 1'b1;
        #1;
        check("d_acq1_ctx", 32'(acquire_ctx_o), 32'd1);
        tick();
        acquire_core_i = 4'd8;
        #1;
        check("d_acq2_ok", 32'(acquire_ok_o), 32'd1);
        check("d_acq2_wrap", 32'(acquire_ctx_o), 32'd0);
        push_exp(1'b0, t + 3, 1, -1);
        tick();
        acquire_req_i = 1'b0; trigger_i = 1'b0;
        #1;
        check("d_nb_free_zero", 32'(nb_free_o), 32'd0);
        wait_until(t + 5);
        check("d_working", 32'(is_working_o), 32'd1);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        check_clean("d_after_clear");
        engine_done_i = 1'b1;
        tick();
        engine_done_i = 1'b0;
        tick();
        tick();
        check("d_still_idle", 32'(is_working_o), 32'd0);

        // Asynchronous reset in the middle of a job.
        t = cyc;
        acquire_req_i = 1'b1; acquire_core_i = 4'd4;
        #1;
        check("e_acq_ctx", 32'(acquire_ctx_o), 32'd0);
        tick();
        acquire_req_i = 1'b0; trigger_i = 1'b1;
        push_exp(1'b0, t + 3, 0, -1);
        tick();
        trigger_i = 1'b0;
        wait_until(t + 5);
        check("e_working", 32'(is_working_o), 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        check_clean("e_async_reset");
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        tick();
        tick();
        check_clean("e_after_reset");

        repeat (3) tick();
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
